// File: rtl/change_dispenser.sv
// Change dispenser: pays owed change in dimes then nickels.
// One coin per request/acknowledge handshake with the coin ejector.
module change_dispenser #(
    parameter int DIME_INIT   = 8,
    parameter int NICKEL_INIT = 8,
    parameter int CNT_W       = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             vend_i,
    input  logic [2:0]       change_i,
    input  logic             refill_i,
    input  logic             eject_ack_i,
    output logic             dime_o,
    output logic             nickel_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             short_o,
    output logic [CNT_W-1:0] dime_cnt_o,
    output logic [CNT_W-1:0] nickel_cnt_o
);

    localparam logic [CNT_W-1:0] DIME_RST   = CNT_W'(DIME_INIT);
    localparam logic [CNT_W-1:0] NICKEL_RST = CNT_W'(NICKEL_INIT);

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        EJECT,
        FINISH
    } state_t;

    state_t           state_q;
    logic [2:0]       rem_q;
    logic [2:0]       owed;
    logic             coin_dime_q;
    logic [CNT_W-1:0] dime_cnt_q;
    logic [CNT_W-1:0] nickel_cnt_q;

    // Owed amount in 5-cent units
    always_comb begin
        owed = 3'd0;
        case (change_i)
            3'b001:  owed = 3'd2;
            3'b010:  owed = 3'd3;
            3'b011:  owed = 3'd4;
            3'b100:  owed = 3'd5;
            default: owed = 3'd0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            rem_q        <= 3'd0;
            coin_dime_q  <= 1'b0;
            dime_cnt_q   <= DIME_RST;
            nickel_cnt_q <= NICKEL_RST;
        end else begin
            case (state_q)
                IDLE: begin
                    if (refill_i) begin
                        dime_cnt_q   <= DIME_RST;
                        nickel_cnt_q <= NICKEL_RST;
                    end
                    if (vend_i) begin
                        rem_q   <= owed;
                        state_q <= SELECT;
                    end
                end
                SELECT: begin
                    if (rem_q == 3'd0) begin
                        state_q <= FINISH;
                    end else if (rem_q >= 3'd2 &&
                                 dime_cnt_q != '0) begin
                        coin_dime_q <= 1'b1;
                        state_q     <= EJECT;
                    end else if (nickel_cnt_q != '0) begin
                        coin_dime_q <= 1'b0;
                        state_q     <= EJECT;
                    end else begin
                        state_q <= FINISH;
                    end
                end
                EJECT: begin
                    if (eject_ack_i) begin
                        // Counters only move here, after SELECT saw >0
                        if (coin_dime_q) begin
                            rem_q      <= rem_q - 3'd2;
                            dime_cnt_q <= dime_cnt_q - 1'b1;
                        end else begin
                            rem_q        <= rem_q - 3'd1;
                            nickel_cnt_q <= nickel_cnt_q - 1'b1;
                        end
                        state_q <= SELECT;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dime_o       = (state_q == EJECT) && coin_dime_q;
    assign nickel_o     = (state_q == EJECT) && !coin_dime_q;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == FINISH);
    assign short_o      = (state_q == FINISH) && (rem_q != 3'd0);
    assign dime_cnt_o   = dime_cnt_q;
    assign nickel_cnt_o = nickel_cnt_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: directed cases plus
// randomized requests checked against an arithmetic change model.
module tb_change_dispenser;

    localparam int DI = 8;
    localparam int NI = 8;
    localparam int W  = 4;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         vend_i = 1'b0;
    logic [2:0]   change_i = 3'd0;
    logic         refill_i = 1'b0;
    logic         eject_ack_i = 1'b0;
    logic         dime_o;
    logic         nickel_o;
    logic         busy_o;
    logic         done_o;
    logic         short_o;
    logic [W-1:0] dime_cnt_o;
    logic [W-1:0] nickel_cnt_o;

    change_dispenser #(
        .DIME_INIT  (DI),
        .NICKEL_INIT(NI),
        .CNT_W      (W)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .vend_i      (vend_i),
        .change_i    (change_i),
        .refill_i    (refill_i),
        .eject_ack_i (eject_ack_i),
        .dime_o      (dime_o),
        .nickel_o    (nickel_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .short_o     (short_o),
        .dime_cnt_o  (dime_cnt_o),
        .nickel_cnt_o(nickel_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int nd;
        int nn;
        int sh;
        int dc;
        int nc;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   md = DI;
    int   mn = NI;
    int   obs_d = 0;
    int   obs_n = 0;
    int   prev_done = 0;
    int   ack_mode = 1;

    task automatic chk(input string name, input int act,
                       input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: greedy dimes first, then nickels, limited by stock
    function automatic exp_t model(input int code, input int d,
                                   input int n);
        int   amt;
        int   r;
        exp_t e;
        case (code)
            1:       amt = 2;
            2:       amt = 3;
            3:       amt = 4;
            4:       amt = 5;
            default: amt = 0;
        endcase
        e.nd = (amt / 2 < d) ? amt / 2 : d;
        r    = amt - 2 * e.nd;
        e.nn = (r < n) ? r : n;
        r    = r - e.nn;
        e.sh = (r != 0) ? 1 : 0;
        e.dc = d - e.nd;
        e.nc = n - e.nn;
        return e;
    endfunction

    always @(posedge clk_i) begin
        #1;
        case (ack_mode)
            0:       eject_ack_i = 1'b0;
            1:       eject_ack_i = 1'b1;
            default: eject_ack_i = ($urandom_range(0, 2) == 0);
        endcase
    end

    // Monitor: counts taken coins, checks each completion
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            obs_d     = 0;
            obs_n     = 0;
            prev_done = 0;
        end else begin
            if (dime_o || nickel_o)
                chk("coin_onehot", int'(dime_o) + int'(nickel_o), 1);
            if (dime_o && eject_ack_i) obs_d++;
            if (nickel_o && eject_ack_i) obs_n++;
            if (done_o) begin
                chk("done_pulse", prev_done, 0);
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("dimes_out", obs_d, e.nd);
                    chk("nickels_out", obs_n, e.nn);
                    chk("short", int'(short_o), e.sh);
                    chk("dime_cnt", int'(dime_cnt_o), e.dc);
                    chk("nickel_cnt", int'(nickel_cnt_o), e.nc);
                end
                obs_d = 0;
                obs_n = 0;
            end
            prev_done = int'(done_o);
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk_i);
        while (busy_o && n < 400) begin
            @(negedge clk_i);
            n++;
        end
        if (busy_o) chk("idle_timeout", 1, 0);
    endtask

    task automatic issue(input int code, input bit refill);
        exp_t e;
        wait_idle();
        if (refill) begin
            md = DI;
            mn = NI;
        end
        e = model(code, md, mn);
        md = e.dc;
        mn = e.nc;
        q.push_back(e);
        vend_i   = 1'b1;
        change_i = 3'(code);
        refill_i = refill;
        @(posedge clk_i);
        #1;
        vend_i   = 1'b0;
        refill_i = 1'b0;
    endtask

    task automatic wait_dime();
        int n = 0;
        @(negedge clk_i);
        while (!dime_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk("dime_req_seen", int'(dime_o), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #23;
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_coin", int'(dime_o | nickel_o), 0);
        chk("rst_short", int'(short_o), 0);
        chk("rst_dcnt", int'(dime_cnt_o), DI);
        chk("rst_ncnt", int'(nickel_cnt_o), NI);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Full stock, code 100, ack tied high
        ack_mode = 1;
        issue(4, 0);
        wait_idle();
        chk("full_dcnt", int'(dime_cnt_o), 6);
        chk("full_ncnt", int'(nickel_cnt_o), 7);

        // Zero-change latency
        for (int c = 0; c < 2; c++) begin
            issue(c == 0 ? 0 : 7, 0);
            @(negedge clk_i);
            chk("zero_lat_n1", int'(done_o), 0);
            @(negedge clk_i);
            chk("zero_lat_n2", int'(done_o), 1);
            chk("zero_coin", obs_d + obs_n, 0);
        end

        // Drain dimes, then nickel-only change
        issue(0, 1);
        for (int i = 0; i < 4; i++) issue(3, 0);
        issue(2, 0);
        wait_idle();
        chk("nick_only_dcnt", int'(dime_cnt_o), 0);
        chk("nick_only_ncnt", int'(nickel_cnt_o), 5);

        // Stalled ack with an ignored vend pulse
        issue(3, 1);
        ack_mode = 0;
        wait_dime();
        for (int i = 0; i < 5; i++) begin
            vend_i   = (i == 1);
            change_i = 3'd4;
            @(negedge clk_i);
            chk("stall_dime", int'(dime_o), 1);
            chk("stall_dcnt", int'(dime_cnt_o), DI);
        end
        vend_i   = 1'b0;
        ack_mode = 1;
        wait_idle();
        chk("stall_end_dcnt", int'(dime_cnt_o), DI - 2);

        // Reset while a dime is requested
        issue(3, 1);
        ack_mode = 0;
        wait_dime();
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_dime", int'(dime_o), 0);
        chk("mid_rst_busy", int'(busy_o), 0);
        q.delete();
        md = DI;
        mn = NI;
        @(negedge clk_i);
        @(negedge clk_i);
        #2;
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("post_rst_dcnt", int'(dime_cnt_o), DI);
        chk("post_rst_ncnt", int'(nickel_cnt_o), NI);
        chk("post_rst_busy", int'(busy_o), 0);

        // Random traffic with random ack delays
        ack_mode = 2;
        for (int i = 0; i < 80; i++) begin
            issue(int'($urandom_range(0, 7)),
                  ($urandom_range(0, 5) == 0));
        end
        wait_idle();
        chk("queue_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
